// File: rtl/lfsr5b_pkg.sv
// lfsr5b_pkg: shared definitions for the 5-bit LFSR (x^5+x^2+1, period 31).
// Used by the generator, the checker and their benches.
//   LFSR_W        state width
//   LFSR_SEED     reset/seed state, also the marker for one full period
//   lfsr5b_state_e checker FSM states
//   lfsr5b_next() one step of the sequence
package lfsr5b_pkg;

  localparam int LFSR_W = 5;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 5'b11111;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lfsr5b_state_e;

  // Bit order {4,3,2,1,0}; the x^2 tap lands on bit 2 from bits 1 and 4.
  function automatic logic [LFSR_W-1:0] lfsr5b_next(input logic [LFSR_W-1:0] x);
    return {x[3], x[2], x[1] ^ x[4], x[0], x[4]};
  endfunction

endpackage

// File: rtl/lfsr5b_checker.sv
// lfsr5b_checker: self-synchronising checker for the 5-bit LFSR state stream.
// Locks after LOCK_MATCHES consecutive correct predictions, then flywheels
// its own prediction and flags every deviating sample.
// Ports:
//   clk          system clock, rising edge
//   rst_b        asynchronous active-low reset
//   valid        data carries a sample this cycle
//   data[4:0]    LFSR state sample
//   clr          synchronous clear of err_cnt
//   locked       checker is synchronised
//   err          one-cycle pulse per mismatch while locked
//   err_cnt      saturating mismatch count
//   stuck        last valid sample was all-zero
//   period_done  one-cycle pulse when the seed arrives correctly while locked
//
// state  | meaning
// HUNT   | waiting for a non-zero sample to seed the prediction
// VERIFY | predicting, counting consecutive matches toward lock
// LOCKED | flywheeling prediction, reporting mismatches
module lfsr5b_checker
  import lfsr5b_pkg::*;
#(
  parameter int LOCK_MATCHES  = 4,
  parameter int UNLOCK_ERRORS = 3,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             valid,
  input  logic [4:0]       data,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             stuck,
  output logic             period_done
);

  localparam int MATCH_W = $clog2(LOCK_MATCHES + 1);
  localparam int MISS_W  = $clog2(UNLOCK_ERRORS + 1);

  lfsr5b_state_e       state_q, state_d;
  logic [LFSR_W-1:0]   pred_q, pred_d;
  logic [MATCH_W-1:0]  match_q, match_d, match_inc;
  logic [MISS_W-1:0]   miss_q, miss_d, miss_inc;
  logic                locked_q, locked_d;
  logic                err_q, err_d;
  logic                stuck_q, stuck_d;
  logic                pd_q, pd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cnt_inc;

  assign match_inc = match_q + MATCH_W'(1);
  assign miss_inc  = miss_q + MISS_W'(1);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= HUNT;
      pred_q   <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      stuck_q  <= 1'b0;
      pd_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pred_q   <= pred_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      stuck_q  <= stuck_d;
      pd_q     <= pd_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pred_d   = pred_q;
    match_d  = match_q;
    miss_d   = miss_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    pd_d     = 1'b0;
    stuck_d  = stuck_q;
    cnt_inc  = 1'b0;

    if (valid) begin
      stuck_d = (data == '0);
      unique case (state_q)
        HUNT: begin
          if (data != '0) begin
            pred_d  = lfsr5b_next(data);
            match_d = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (data == '0) begin
            match_d = '0;
            state_d = HUNT;
          end else if (data == pred_q) begin
            pred_d = lfsr5b_next(data);
            if (match_inc == MATCH_W'(LOCK_MATCHES)) begin
              match_d  = '0;
              miss_d   = '0;
              locked_d = 1'b1;
              state_d  = LOCKED;
            end else begin
              match_d = match_inc;
            end
          end else begin
            // Wrong but non-zero: treat it as a fresh seed.
            pred_d  = lfsr5b_next(data);
            match_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel: the prediction never follows a bad sample.
          pred_d = lfsr5b_next(pred_q);
          if (data == pred_q) begin
            miss_d = '0;
            pd_d   = (data == LFSR_SEED);
          end else begin
            err_d   = 1'b1;
            cnt_inc = 1'b1;
            if (miss_inc == MISS_W'(UNLOCK_ERRORS)) begin
              miss_d   = '0;
              locked_d = 1'b0;
              state_d  = HUNT;
            end else begin
              miss_d = miss_inc;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign locked      = locked_q;
  assign err         = err_q;
  assign err_cnt     = cnt_q;
  assign stuck       = stuck_q;
  assign period_done = pd_q;

endmodule
